// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and field positions.
// The D-stage legality unit imports the same definitions when it raises RI.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int IM_LO        = 10;
    localparam int IM_HI        = 15;
    localparam int CAUSE_BD_BIT = 31;
    localparam int EXC_LO       = 2;
    localparam int EXC_HI       = 6;

    localparam logic [31:0] PRID_DEFAULT = 32'h2019_0701;
    // Exception vector, consumed by the PC mux only.
    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_unit_arbiter.sv
// Combinational interrupt/exception arbitration for CP0.
// An enabled interrupt wins over a simultaneous M-stage exception.
module cp0_arbiter
    import cp0_pkg::*;
(
    input  logic [5:0] i_hwint,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [4:0] i_exc_code_m,
    output logic       o_int_req,
    output logic       o_exc_req,
    output logic       o_take,
    output logic [4:0] o_next_exc_code
);

    logic w_int_req;
    logic w_exc_req;

    // Live HWInt is used, not the latched IP, so the request has no cycle of lag.
    assign w_int_req       = (|(i_hwint & i_im)) & i_ie & ~i_exl;
    assign w_exc_req       = (i_exc_code_m != EXC_INT) & ~i_exl;
    assign o_int_req       = w_int_req;
    assign o_exc_req       = w_exc_req;
    assign o_take          = w_int_req | w_exc_req;
    assign o_next_exc_code = w_int_req ? EXC_INT : i_exc_code_m;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file (SR, Cause, EPC, PRId) with exception entry, eret and mtc0/mfc0.
// Per-edge priority: reset, then exception entry, then eret, then mtc0.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = PRID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_take;
    logic [4:0]  w_next_exc_code;
    logic [31:0] w_victim_pc;
    logic [31:0] w_victim_epc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    cp0_arbiter u_arbiter (
        .i_hwint         (HWInt),
        .i_im            (r_im),
        .i_ie            (r_ie),
        .i_exl           (r_exl),
        .i_exc_code_m    (ExcCode_M),
        .o_int_req       (w_int_req),
        .o_exc_req       (w_exc_req),
        .o_take          (w_take),
        .o_next_exc_code (w_next_exc_code)
    );

    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign w_victim_pc  = word_align(PC_M);
    assign w_victim_epc = BD_M ? (w_victim_pc - 32'd4) : w_victim_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= HWInt;
            if (w_take) begin
                r_exl      <= 1'b1;
                r_bd       <= BD_M;
                r_exc_code <= w_next_exc_code;
                r_epc      <= w_victim_epc;
            end else if (EXLClr) begin
                r_exl <= 1'b0;
            end else if (WE) begin
                // Cause is read-only to software; PRId and unknown numbers are ignored.
                if (A2 == REG_SR) begin
                    r_im  <= DIn[IM_HI:IM_LO];
                    r_exl <= DIn[SR_EXL_BIT];
                    r_ie  <= DIn[SR_IE_BIT];
                end else if (A2 == REG_EPC) begin
                    r_epc <= word_align(DIn);
                end
            end
        end
    end

    always_comb begin
        w_sr                      = '0;
        w_sr[IM_HI:IM_LO]         = r_im;
        w_sr[SR_EXL_BIT]          = r_exl;
        w_sr[SR_IE_BIT]           = r_ie;
        w_cause                   = '0;
        w_cause[CAUSE_BD_BIT]     = r_bd;
        w_cause[IM_HI:IM_LO]      = r_ip;
        w_cause[EXC_HI:EXC_LO]    = r_exc_code;
    end

    // No write-to-read bypass: the pipeline stalls mfc0 behind an M-stage mtc0.
    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = w_sr;
            REG_CAUSE: DOut = w_cause;
            REG_EPC:   DOut = r_epc;
            REG_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end

    assign IntReq = w_take;
    assign EPC    = r_epc;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
Coprocessor-0 exception/interrupt responder for the P7 five-stage MIPS pipeline. It is the receiving end of the decode-stage legality check: a reserved-instruction (RI) flag raised in D travels down the pipe as an exception code and arrives here in M, together with the other exception sources and the external interrupt lines. The block holds SR, Cause, EPC and PRId, arbitrates interrupt against exception, and raises the flush/redirect request. It also services mfc0, mtc0 and eret.

Parameters:
PRID, 32'h2019_0701, read-only value returned for register 15.
HANDLER_PC, 32'h0000_4180, redirect target; exported for the PC mux only, not used internally.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
A1  in  5  mfc0 read register number (rd field)
A2  in  5  mtc0 write register number (rd field)
DIn  in  32  mtc0 write data (GPR[rt])
WE  in  1  mtc0 write enable (M-stage mtc0, not flushed)
PC_M  in  32  PC of the M-stage instruction (victim)
BD_M  in  1  M-stage instruction sits in a branch delay slot
ExcCode_M  in  5  pending exception code from M; 0 means none. Values: 4 AdEL, 5 AdES, 10 RI, 12 Ov
HWInt  in  6  external interrupt lines [7:2]
EXLClr  in  1  eret in M
IntReq  out  1  take exception/interrupt this cycle (combinational)
EPC  out  32  current EPC, used by eret redirect
DOut  out  32  mfc0 read data (combinational on A1)

Behaviour:
- Register fields:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, bits[1:0] forced 0.
  - PRId(15): PRID.
- Reset (synchronous): SR=0, Cause=0, EPC=0. Outputs follow: IntReq=0, EPC=0.
- IP[15:10] <= HWInt every cycle, including while EXL=1. One-cycle register delay; Cause reads show HWInt from the previous edge.
- int_req = |(HWInt & IM) & IE & ~EXL. Uses live HWInt, not IP.
- exc_req = (ExcCode_M != 0) & ~EXL.
- IntReq = int_req | exc_req.
- On a clock edge with IntReq=1:
  - EXL<=1.
  - BD<=BD_M.
  - ExcCode <= int_req ? 0 : ExcCode_M. Interrupt beats exception.
  - EPC <= BD_M ? {PC_M[31:2],2'b0}-4 : {PC_M[31:2],2'b0}.
- Priority per edge: reset > IntReq > EXLClr > mtc0 write.
  - An mtc0 or eret in the victim slot is discarded when IntReq=1.
- EXLClr=1 (with IntReq=0): EXL<=0. EPC output must be stable in the same cycle for the redirect.
- WE=1 (with IntReq=0, EXLClr=0):
  - A2=12 writes IM, EXL, IE.
  - A2=14 writes EPC with bits[1:0] cleared.
  - A2=13 writes nothing; Cause is read-only to software.
  - A2=15 and other numbers are ignored.
- DOut = selected register for A1 in {12,13,14,15}, else 0.
  - No internal bypass: a write and a read in the same cycle return the old value. The pipeline stalls mfc0 in E behind mtc0 in M.
- Latency: IntReq is 0 cycles (combinational). All register updates take 1 cycle.
- Reset while EXL=1: all state clears. HWInt asserted during reset is ignored and is not latched into IP until the first non-reset edge.
- HWInt held high after handling: while EXL=1, IntReq stays 0. After eret the next cycle re-requests if still pending and IE=1.

Decomposition:
- Shared package/define file:
  - Register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - Field bit positions.
  - These constants are shared with the D-stage legality unit, which emits RI.
- One sub-module is natural: cp0_arbiter. It is combinational and computes int_req/exc_req/IntReq and the next ExcCode. The register file stays in cp0_unit.

Test Plan:
1. Reset, then mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), HWInt=6'b000001 -> IntReq=1 next cycle. After the edge: Cause=32'h0000_0400, ExcCode=0, EXL=1, EPC=PC_M.
2. ExcCode_M=10 (RI), PC_M=32'h0000_3010, BD_M=0, EXL=0 -> IntReq=1. Then Cause[6:2]=10 and EPC=32'h0000_3010.
3. ExcCode_M=12, BD_M=1, PC_M=32'h0000_3024 -> EPC=32'h0000_3020 and Cause[31]=1.
4. Interrupt and ExcCode_M=4 in the same cycle -> ExcCode=0. A simultaneous WE=1 to EPC is discarded.
5. EXL=1, ExcCode_M=10 -> IntReq=0. Then EXLClr=1 -> EXL=0, and the pending ExcCode_M=10 raises IntReq the following cycle.
6. mfc0 A1=15 -> DOut=PRID. A1=13 during WE to 13 -> Cause unchanged. Reset asserted mid-handler -> SR=Cause=EPC=0.
